fpu_normalize: RTL and testbench
================================

# fpu_normalize

Back end of the FPU add/sub pipe. Consumes the unnormalized sum produced by the adder stage (`add_valid`, `add_mantissa`, `add_exponent`, `add_sign`, `add_dest`). Normalizes it, rounds to nearest-even, and packs an IEEE-754 single. Results are queued for the register-file writeback port and delivered through a valid/ready handshake; the block raises a stall toward FPU issue before the queue can overflow, because the adder itself cannot be stalled.

## Interface
- `DEPTH`, 8, result FIFO entries (power of two, ≥ 8)
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `add_valid`  in  1  adder result present this cycle
- `add_mantissa`  in  32  bit31 = carry, bit30 = hidden position, 29:7 = fraction, 6 = guard, 5:0 = sticky field
- `add_exponent`  in  8  biased exponent of bit30
- `add_sign`  in  1  result sign (already 0 for exact zero)
- `add_dest`  in  5  destination register
- `wb_valid`  out  1  FIFO head valid
- `wb_ready`  in  1  writeback port accepts head
- `wb_data`  out  32  packed IEEE single
- `wb_dest`  out  5  destination register
- `fpu_stall`  out  1  FPU issue must not start an add/sub this cycle

## Operation
- **Stage N1 (LZC/shift).**
  - Find the leading-one position p of `add_mantissa`.
  - p = 31: shift right 1; bit0 ORs into sticky; e = exp+1.
  - p ≤ 30: shift = min(30−p, exp−1), shift left; e = exp − shift.
  - If e would drop below 1, the value is subnormal: clamp e = 1 and leave the hidden bit 0.
  - Mantissa = 0: mark zero; the result is {sign, 31'b0}.
- **Stage N2 (round/pack).**
  - Fields: frac = bits29:7, G = bit6, S = |bits5:0.
  - Round up iff G & (S | frac[0]).
  - Increment {hidden, frac} as a 24-bit value; on carry-out set e = e+1 and frac = 0.
  - Exponent field: 0 if hidden = 0 (subnormal), else e.
  - If e ≥ 255 (before or after rounding): output {sign, 8'hFF, 23'b0} (infinity).
  - NaN/infinity inputs are out of scope: `add_exponent` = 255 yields infinity.
- **FIFO.**
  - N2 writes into the FIFO.
  - Head is popped when `wb_valid & wb_ready`.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Ordering is strictly preserved.
  - Pointers wrap modulo `DEPTH`.
- **Credit/stall.**
  - in_flight = FIFO count + N1 valid + N2 valid.
  - `fpu_stall` = in_flight ≥ DEPTH − 4, registered.
  - The margin of 4 covers 2 adder stages + 2 normalizer stages that may already be committed.
- **Overflow.** A push while the FIFO is full is a design error. Flag it with an assertion; never silently drop.

## Timing
- Latency: `add_valid` at cycle t → entry visible at the FIFO head (`wb_valid`) at t+2 if the FIFO was empty.
- Throughput: one result per cycle. N1 and N2 never stall.
- Reset values:
  - `wb_valid` = 0, `wb_data` = 0, `wb_dest` = 0, `fpu_stall` = 0.
  - FIFO count = 0; N1/N2 valid = 0.
- Reset mid-operation: all in-flight and queued results are discarded. No writeback occurs in the cycle after `reset` deasserts.
- `wb_data`/`wb_dest` are held stable while `wb_valid & !wb_ready`.
- Empty FIFO: `wb_valid` = 0, and `wb_data` is don't-care.
- Full FIFO: `fpu_stall` has been high for at least 4 cycles before this state is reached.

## Structure
- Package `fpu_pkg` holds:
  - `EXP_BIAS` = 127, `EXP_MAX` = 255
  - mantissa bit-position constants (`M_CARRY` = 31, `M_HIDDEN` = 30, `M_GUARD` = 6)
  - `STALL_MARGIN` = 4
  - typedef `fpu_result_t` {data[31:0], dest[4:0]}
- Sub-module `fpu_result_fifo`: a synchronous FIFO parameterized on `DEPTH` and `fpu_result_t`, exposing count, push, pop, head, and full/empty.
- LZC is a combinational function inside `fpu_normalize`.

## Test plan
- **1.0+1.0:** mantissa 0x8000_0000, exp 127, sign 0 → `wb_data` 0x4000_0000 at t+2.
- **Cancellation:** mantissa 0x0000_0080, exp 127 → 0x3400_0000. Zero: mantissa 0, sign 0 → 0x0000_0000.
- **Ties-to-even:**
  - 0x4000_0040, exp 127 → 0x3F80_0000 (tie, even, no round).
  - 0x4000_00C0 → 0x3F80_0002.
  - 0x7FFF_FFC0, exp 127 → 0x4000_0000 (round carry bumps exponent).
- **Limits:**
  - mantissa 0x8000_0000, exp 254 → 0x7F80_0000.
  - mantissa 0x2000_0000, exp 1 → 0x0040_0000 (subnormal, no shift).
- **Backpressure:**
  - `wb_ready` = 0 with `add_valid` every cycle the bench is allowed to issue → `fpu_stall` asserts when in_flight reaches 4 (DEPTH = 8).
  - No overflow assertion fires.
  - After releasing `wb_ready`, all results drain in issue order with their correct `wb_dest`.
- **Reset mid-stream:** assert `reset` for 1 cycle with 3 entries queued and 2 in flight → `wb_valid` = 0 and `fpu_stall` = 0 next cycle; a new add then completes with t+2 latency.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and result record for the FPU add/sub normalizer back end.
package fpu_pkg;

    localparam int EXP_BIAS     = 127;
    localparam int EXP_MAX      = 255;
    localparam int M_CARRY      = 31;
    localparam int M_HIDDEN     = 30;
    localparam int M_GUARD      = 6;
    localparam int STALL_MARGIN = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
    } fpu_result_t;

endpackage

// File: rtl/fpu_normalize_chk.sv
// Design-rule checks for the normalizer result queue.
module fpu_normalize_chk (
    input logic clock,
    input logic reset,
    input logic push,
    input logic pop,
    input logic full
);

    // The adder cannot be stalled, so a push into a full queue would lose a result.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full && !pop))
        else $error("result FIFO overflow: push while full");

endmodule

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO; pointers wrap modulo DEPTH (power of two).
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fpu_result_t              push_data,
    input  logic                     pop,
    output fpu_result_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    fpu_result_t   mem_r [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign do_pop_s  = pop & ~empty;
    // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fpu_normalize.sv
// Normalize, round-to-nearest-even and pack adder sums into IEEE singles,
// queueing them for writeback with an early stall toward FPU issue.
module fpu_normalize
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        add_valid,
    input  logic [31:0] add_mantissa,
    input  logic [7:0]  add_exponent,
    input  logic        add_sign,
    input  logic [4:0]  add_dest,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        fpu_stall
);

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [4:0] lead_one(input logic [31:0] m);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                pos = 5'(i);
            end
        end
        return pos;
    endfunction

    // N1 combinational results
    logic [4:0]  n1_pos_s;
    logic [4:0]  n1_want_s;
    logic [7:0]  n1_max_s;
    logic [4:0]  n1_shift_s;
    logic [30:0] n1_mant_s;
    logic [8:0]  n1_exp_s;

    // N1 -> N2 pipeline register
    logic        n1_valid_r;
    logic        n1_sign_r;
    logic        n1_zero_r;
    logic [4:0]  n1_dest_r;
    logic [30:0] n1_mant_r;
    logic [8:0]  n1_exp_r;

    // N2 combinational results
    logic        n2_round_s;
    logic [24:0] n2_sum_s;
    logic        n2_hidden_s;
    logic [22:0] n2_frac_s;
    logic [8:0]  n2_exp_s;
    logic [31:0] n2_data_s;

    fpu_result_t      push_data_s;
    fpu_result_t      head_s;
    logic [CW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic [CW:0]      in_flight_s;
    logic             stall_r;

    // N1: leading-one detect and normalizing shift, bounded by the exponent floor.
    always_comb begin
        n1_pos_s   = lead_one(add_mantissa);
        n1_want_s  = 5'd30 - n1_pos_s;
        n1_max_s   = (add_exponent == 8'd0) ? 8'd0 : (add_exponent - 8'd1);
        n1_shift_s = 5'd0;
        n1_mant_s  = 31'd0;
        n1_exp_s   = 9'd0;
        if (add_mantissa[M_CARRY]) begin
            n1_mant_s = {add_mantissa[31:2], add_mantissa[1] | add_mantissa[0]};
            n1_exp_s  = {1'b0, add_exponent} + 9'd1;
        end else begin
            n1_shift_s = ({3'b000, n1_want_s} <= n1_max_s) ? n1_want_s : n1_max_s[4:0];
            n1_mant_s  = 31'(add_mantissa << n1_shift_s);
            n1_exp_s   = (add_exponent == 8'd0) ? 9'd1
                                                : ({1'b0, add_exponent} - {4'b0000, n1_shift_s});
        end
    end

    // N1 stage register.
    always_ff @(posedge clock) begin
        if (reset) begin
            n1_valid_r <= 1'b0;
            n1_sign_r  <= 1'b0;
            n1_zero_r  <= 1'b0;
            n1_dest_r  <= 5'd0;
            n1_mant_r  <= 31'd0;
            n1_exp_r   <= 9'd0;
        end else begin
            n1_valid_r <= add_valid;
            n1_sign_r  <= add_sign;
            n1_zero_r  <= (add_mantissa == 32'd0);
            n1_dest_r  <= add_dest;
            n1_mant_r  <= n1_mant_s;
            n1_exp_r   <= n1_exp_s;
        end
    end

    // N2: round to nearest-even on the 24-bit significand, then pack.
    always_comb begin
        n2_round_s = n1_mant_r[M_GUARD] & ((|n1_mant_r[5:0]) | n1_mant_r[7]);
        n2_sum_s   = {1'b0, n1_mant_r[M_HIDDEN:7]} + {24'd0, n2_round_s};
        if (n2_sum_s[24]) begin
            n2_hidden_s = 1'b1;
            n2_frac_s   = 23'd0;
            n2_exp_s    = n1_exp_r + 9'd1;
        end else begin
            n2_hidden_s = n2_sum_s[23];
            n2_frac_s   = n2_sum_s[22:0];
            n2_exp_s    = n1_exp_r;
        end
        if (n1_zero_r) begin
            n2_data_s = {n1_sign_r, 31'd0};
        end else if (n2_exp_s >= 9'(EXP_MAX)) begin
            n2_data_s = {n1_sign_r, 8'hFF, 23'd0};
        end else begin
            n2_data_s = {n1_sign_r, (n2_hidden_s ? n2_exp_s[7:0] : 8'd0), n2_frac_s};
        end
    end

    assign push_data_s = '{data: n2_data_s, dest: n1_dest_r};
    assign pop_s       = ~empty_s & wb_ready;

    fpu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (n1_valid_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    fpu_normalize_chk u_chk (
        .clock (clock),
        .reset (reset),
        .push  (n1_valid_r),
        .pop   (pop_s),
        .full  (full_s)
    );

    assign in_flight_s = {1'b0, count_s} + {{CW{1'b0}}, add_valid} + {{CW{1'b0}}, n1_valid_r};

    // Issue stall: raised with enough margin for results already committed upstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_r <= 1'b0;
        end else begin
            stall_r <= (in_flight_s >= (CW+1)'(DEPTH - STALL_MARGIN));
        end
    end

    assign fpu_stall = stall_r;
    assign wb_valid  = ~empty_s;
    assign wb_data   = empty_s ? 32'd0 : head_s.data;
    assign wb_dest   = empty_s ? 5'd0  : head_s.dest;

endmodule

// File: tb/tb_fpu_normalize.sv
// Self-checking bench for fpu_normalize: vector table plus backpressure and reset sequences.
module tb_fpu_normalize;
    import fpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        add_valid;
    logic [31:0] add_mantissa;
    logic [7:0]  add_exponent;
    logic        add_sign;
    logic [4:0]  add_dest;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        fpu_stall;

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  expo;
        logic        sign;
        logic [4:0]  dest;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs [13];
    logic [36:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    fpu_normalize #(.DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .add_valid    (add_valid),
        .add_mantissa (add_mantissa),
        .add_exponent (add_exponent),
        .add_sign     (add_sign),
        .add_dest     (add_dest),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_dest      (wb_dest),
        .fpu_stall    (fpu_stall)
    );

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        add_valid    = 1'b1;
        add_mantissa = v.mant;
        add_exponent = v.expo;
        add_sign     = v.sign;
        add_dest     = v.dest;
        sb_q.push_back({v.data, v.dest});
    endtask

    task automatic idle();
        add_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clock);
        check("drain_complete", 37'(sb_q.size()), 37'd0);
    endtask

    task automatic lat_check(input vec_t v);
        @(posedge clock); #1;
        drive(v);
        @(negedge clock);
        check("latency_t0_valid", {36'd0, wb_valid}, 37'd0);
        @(posedge clock); #1;
        idle();
        @(negedge clock);
        check("latency_t1_valid", {36'd0, wb_valid}, 37'd0);
        @(negedge clock);
        check("latency_t2_valid", {36'd0, wb_valid}, 37'd1);
    endtask

    // Scoreboard: every accepted writeback must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wb: got %h/%0d, expected nothing", wb_data, wb_dest);
            end else begin
                check("wb_result", {wb_data, wb_dest}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   stall_at;
        int   issued;

        vecs[0]  = '{32'h8000_0000, 8'd127, 1'b0, 5'd1,  32'h4000_0000};
        vecs[1]  = '{32'h0000_0080, 8'd127, 1'b0, 5'd2,  32'h3400_0000};
        vecs[2]  = '{32'h0000_0000, 8'd127, 1'b0, 5'd3,  32'h0000_0000};
        vecs[3]  = '{32'h4000_0040, 8'd127, 1'b0, 5'd4,  32'h3F80_0000};
        vecs[4]  = '{32'h4000_00C0, 8'd127, 1'b0, 5'd5,  32'h3F80_0002};
        vecs[5]  = '{32'h7FFF_FFC0, 8'd127, 1'b0, 5'd6,  32'h4000_0000};
        vecs[6]  = '{32'h8000_0000, 8'd254, 1'b0, 5'd7,  32'h7F80_0000};
        vecs[7]  = '{32'h2000_0000, 8'd1,   1'b0, 5'd8,  32'h0040_0000};
        vecs[8]  = '{32'h8000_0000, 8'd127, 1'b1, 5'd9,  32'hC000_0000};
        vecs[9]  = '{32'h8000_0081, 8'd127, 1'b0, 5'd10, 32'h4000_0001};
        vecs[10] = '{32'h3FFF_FFC0, 8'd1,   1'b0, 5'd11, 32'h0080_0000};
        vecs[11] = '{32'h0000_0080, 8'd10,  1'b0, 5'd12, 32'h0000_0200};
        vecs[12] = '{32'h4000_0000, 8'd255, 1'b0, 5'd13, 32'h7F80_0000};

        reset = 1'b1;
        add_valid = 1'b0; add_mantissa = 32'd0; add_exponent = 8'd0;
        add_sign = 1'b0; add_dest = 5'd0; wb_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_wb_valid", {36'd0, wb_valid}, 37'd0);
        check("reset_wb_data", {5'd0, wb_data}, 37'd0);
        check("reset_wb_dest", {32'd0, wb_dest}, 37'd0);
        check("reset_fpu_stall", {36'd0, fpu_stall}, 37'd0);

        // 1.0 + 1.0 with exact two-cycle latency, then the table back to back.
        wb_ready = 1'b1;
        lat_check(vecs[0]);
        wait_drain(10);
        for (int i = 0; i < 13; i++) begin
            @(posedge clock); #1;
            drive(vecs[i]);
        end
        @(posedge clock); #1;
        idle();
        wait_drain(20);

        // Backpressure: issue only while not stalled, writeback blocked.
        @(posedge clock); #1;
        wb_ready = 1'b0;
        stall_at = -1;
        issued = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock); #1;
            if (fpu_stall) begin
                idle();
                if (stall_at < 0) stall_at = c;
            end else begin
                v = '{32'h8000_0000, 8'(127 + issued), 1'b0, 5'(16 + issued),
                      32'h4000_0000 + (32'(issued) << 23)};
                drive(v);
                issued++;
            end
        end
        check("stall_first_cycle", 37'(stall_at), 37'd4);
        check("bp_issued", 37'(issued), 37'd4);
        @(negedge clock);
        check("bp_stall_held", {36'd0, fpu_stall}, 37'd1);
        check("bp_head_hold_a", {wb_data, wb_dest}, sb_q[0]);
        repeat (3) @(negedge clock);
        check("bp_head_hold_b", {wb_data, wb_dest}, sb_q[0]);
        @(posedge clock); #1;
        wb_ready = 1'b1;
        wait_drain(30);
        repeat (3) @(negedge clock);
        check("bp_stall_release", {36'd0, fpu_stall}, 37'd0);

        // Reset with three entries queued and two in flight.
        @(posedge clock); #1;
        wb_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            drive(vecs[3]);
            if (c == 4) reset = 1'b1;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        idle();
        sb_q.delete();
        @(negedge clock);
        check("rst_mid_wb_valid", {36'd0, wb_valid}, 37'd0);
        check("rst_mid_fpu_stall", {36'd0, fpu_stall}, 37'd0);
        @(negedge clock);
        check("rst_mid_no_stale", {36'd0, wb_valid}, 37'd0);
        wb_ready = 1'b1;
        lat_check(vecs[4]);
        wait_drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
